// File: rtl/iq_rx_frame_buffer.sv
// RX IQ frame FIFO between the DDC decimation output and the parallel-bus reader.
// Frames are {RX1_I, RX1_Q, RX2_I, RX2_Q}; sticky overrun/underrun flags feed the bus status byte.
module iq_rx_frame_buffer #(
  parameter int DEPTH_LOG2 = 4,
  parameter int SAMPLE_W   = 24
) (
  input  logic                       clk_in,
  input  logic                       reset,
  input  logic                       IQ_VALID,
  input  logic signed [SAMPLE_W-1:0] RX1_I,
  input  logic signed [SAMPLE_W-1:0] RX1_Q,
  input  logic signed [SAMPLE_W-1:0] RX2_I,
  input  logic signed [SAMPLE_W-1:0] RX2_Q,
  input  logic                       rx2_enable,
  input  logic                       IQ_RX_READ_REQ,
  input  logic                       IQ_RX_READ_CLK,
  input  logic                       CLEAR_FLAGS,
  output logic signed [SAMPLE_W-1:0] RD_RX1_I,
  output logic signed [SAMPLE_W-1:0] RD_RX1_Q,
  output logic signed [SAMPLE_W-1:0] RD_RX2_I,
  output logic signed [SAMPLE_W-1:0] RD_RX2_Q,
  output logic                       DATA_READY,
  output logic [DEPTH_LOG2:0]        FIFO_LEVEL,
  output logic                       IQ_OVERRUN,
  output logic                       IQ_UNDERRUN
);

  localparam int DEPTH   = 2 ** DEPTH_LOG2;
  localparam int FRAME_W = 4 * SAMPLE_W;
  localparam int LVL_W   = DEPTH_LOG2 + 1;

  logic [FRAME_W-1:0]    mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  ready_q, ready_d;
  logic                  ovr_q, ovr_d;
  logic                  und_q, und_d;
  logic                  rx2_en_q, rx2_en_d;
  logic [FRAME_W-1:0]    rd_frame_q, rd_frame_d;
  logic                  rd_clk_prev_q, rd_clk_prev_d;

  logic                  flush, pop_evt, empty, full;
  logic                  pop_ok, push_ok, ovr_evt, und_evt;
  logic [FRAME_W-1:0]    wr_frame;

  always_comb begin
    flush    = (rx2_enable != rx2_en_q);
    pop_evt  = IQ_RX_READ_CLK & ~rd_clk_prev_q & IQ_RX_READ_REQ;
    empty    = (level_q == '0);
    full     = (level_q == LVL_W'(DEPTH));
    pop_ok   = pop_evt & ~empty & ~flush;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
    push_ok  = IQ_VALID & ~flush & (~full | pop_ok);
    ovr_evt  = IQ_VALID & ~flush & full & ~pop_ok;
    und_evt  = pop_evt & empty;
    wr_frame = {RX1_I, RX1_Q,
                rx2_enable ? RX2_I : {SAMPLE_W{1'b0}},
                rx2_enable ? RX2_Q : {SAMPLE_W{1'b0}}};

    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    level_d       = level_q;
    rd_frame_d    = rd_frame_q;
    rx2_en_d      = rx2_enable;
    rd_clk_prev_d = IQ_RX_READ_CLK;

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_ok) begin
        rd_ptr_d   = rd_ptr_q + 1'b1;
        rd_frame_d = mem_q[rd_ptr_q];
      end
      level_d = level_q + LVL_W'(push_ok) - LVL_W'(pop_ok);
    end

    ready_d = (level_d != '0);
    // A new event in the clearing cycle keeps the flag set.
    ovr_d   = ovr_evt | (ovr_q & ~CLEAR_FLAGS);
    und_d   = und_evt | (und_q & ~CLEAR_FLAGS);
  end

  always_ff @(posedge clk_in) begin
    // Edge history keeps tracking during reset so a level held across release is not a pop.
    rd_clk_prev_q <= rd_clk_prev_d;
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      ready_q    <= 1'b0;
      ovr_q      <= 1'b0;
      und_q      <= 1'b0;
      rx2_en_q   <= 1'b0;
      rd_frame_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      ready_q    <= ready_d;
      ovr_q      <= ovr_d;
      und_q      <= und_d;
      rx2_en_q   <= rx2_en_d;
      rd_frame_q <= rd_frame_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset && push_ok) mem_q[wr_ptr_q] <= wr_frame;
  end

  assign RD_RX1_I    = rd_frame_q[4*SAMPLE_W-1 -: SAMPLE_W];
  assign RD_RX1_Q    = rd_frame_q[3*SAMPLE_W-1 -: SAMPLE_W];
  assign RD_RX2_I    = rd_frame_q[2*SAMPLE_W-1 -: SAMPLE_W];
  assign RD_RX2_Q    = rd_frame_q[SAMPLE_W-1   -: SAMPLE_W];
  assign DATA_READY  = ready_q;
  assign FIFO_LEVEL  = level_q;
  assign IQ_OVERRUN  = ovr_q;
  assign IQ_UNDERRUN = und_q;

endmodule

// File: tb/tb_iq_rx_frame_buffer.sv
// Directed bench for iq_rx_frame_buffer: per-cycle vector table plus hand sequences
// for overrun, full push+pop, flush on rx2_enable change and reset corner cases.
module tb_iq_rx_frame_buffer;

  localparam int SW = 24;

  logic          clk_in = 1'b0;
  logic          reset;
  logic          IQ_VALID;
  logic [SW-1:0] RX1_I, RX1_Q, RX2_I, RX2_Q;
  logic          rx2_enable;
  logic          IQ_RX_READ_REQ, IQ_RX_READ_CLK, CLEAR_FLAGS;
  logic [SW-1:0] RD_RX1_I, RD_RX1_Q, RD_RX2_I, RD_RX2_Q;
  logic          DATA_READY;
  logic [4:0]    FIFO_LEVEL;
  logic          IQ_OVERRUN, IQ_UNDERRUN;

  iq_rx_frame_buffer #(.DEPTH_LOG2(4), .SAMPLE_W(SW)) dut (
    .clk_in(clk_in), .reset(reset), .IQ_VALID(IQ_VALID),
    .RX1_I(RX1_I), .RX1_Q(RX1_Q), .RX2_I(RX2_I), .RX2_Q(RX2_Q),
    .rx2_enable(rx2_enable), .IQ_RX_READ_REQ(IQ_RX_READ_REQ),
    .IQ_RX_READ_CLK(IQ_RX_READ_CLK), .CLEAR_FLAGS(CLEAR_FLAGS),
    .RD_RX1_I(RD_RX1_I), .RD_RX1_Q(RD_RX1_Q), .RD_RX2_I(RD_RX2_I), .RD_RX2_Q(RD_RX2_Q),
    .DATA_READY(DATA_READY), .FIFO_LEVEL(FIFO_LEVEL),
    .IQ_OVERRUN(IQ_OVERRUN), .IQ_UNDERRUN(IQ_UNDERRUN)
  );

  always #5 clk_in = ~clk_in;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic          v;
    logic [SW-1:0] r1i, r2i;
    logic          en, req, rclk, clr;
    logic [4:0]    lvl;
    logic          rdy;
    logic [SW-1:0] e1i, e2i;
    logic          ovr, und;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic v, logic [SW-1:0] r1i, logic [SW-1:0] r2i,
                              logic en, logic req, logic rclk, logic clr,
                              logic [4:0] lvl, logic rdy, logic [SW-1:0] e1i,
                              logic [SW-1:0] e2i, logic ovr, logic und);
    vec_t t;
    t.v = v; t.r1i = r1i; t.r2i = r2i; t.en = en; t.req = req; t.rclk = rclk; t.clr = clr;
    t.lvl = lvl; t.rdy = rdy; t.e1i = e1i; t.e2i = e2i; t.ovr = ovr; t.und = und;
    vq.push_back(t);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_sample(input logic [SW-1:0] r1i, input logic [SW-1:0] r2i);
    RX1_I = r1i; RX1_Q = ~r1i; RX2_I = r2i; RX2_Q = ~r2i;
  endtask

  task automatic pop_once();
    IQ_RX_READ_CLK = 1'b1; tick();
  endtask

  task automatic push_n(input int n, input int base);
    for (int k = 0; k < n; k++) begin
      IQ_VALID = 1'b1;
      set_sample(SW'(base + k), SW'(base + 100 + k));
      tick();
    end
    IQ_VALID = 1'b0;
  endtask

  initial begin
    logic [SW-1:0] e;
    reset = 1'b1; IQ_VALID = 1'b0; set_sample('0, '0);
    rx2_enable = 1'b1; IQ_RX_READ_REQ = 1'b0; IQ_RX_READ_CLK = 1'b0; CLEAR_FLAGS = 1'b0;
    tick(); tick();
    chk("reset_level", FIFO_LEVEL, 0);
    chk("reset_ready", DATA_READY, 0);
    chk("reset_rd1i", RD_RX1_I, 0);
    chk("reset_ovr", IQ_OVERRUN, 0);
    chk("reset_und", IQ_UNDERRUN, 0);
    reset = 1'b0;
    tick();  // shadow catches up with rx2_enable=1 (flush of an empty FIFO)

    //   v  r1i       r2i       en req rclk clr  lvl rdy e1i       e2i       ovr und
    add(1, 24'h1,    24'h11,    1, 0, 0, 0,    1, 1, 24'h0,    24'h0,     0, 0);
    add(1, 24'h2,    24'h22,    1, 0, 0, 0,    2, 1, 24'h0,    24'h0,     0, 0);
    add(1, 24'h3,    24'h33,    1, 0, 0, 0,    3, 1, 24'h0,    24'h0,     0, 0);
    add(0, 24'h0,    24'h0,     1, 1, 1, 0,    2, 1, 24'h1,    24'h11,    0, 0);
    add(0, 24'h0,    24'h0,     1, 1, 0, 0,    2, 1, 24'h1,    24'h11,    0, 0);
    add(0, 24'h0,    24'h0,     1, 1, 1, 0,    1, 1, 24'h2,    24'h22,    0, 0);
    add(0, 24'h0,    24'h0,     1, 1, 0, 0,    1, 1, 24'h2,    24'h22,    0, 0);
    add(0, 24'h0,    24'h0,     1, 1, 1, 0,    0, 0, 24'h3,    24'h33,    0, 0);
    add(0, 24'h0,    24'h0,     1, 1, 0, 0,    0, 0, 24'h3,    24'h33,    0, 0);
    add(0, 24'h0,    24'h0,     1, 1, 1, 0,    0, 0, 24'h3,    24'h33,    0, 1);
    add(0, 24'h0,    24'h0,     1, 1, 0, 1,    0, 0, 24'h3,    24'h33,    0, 0);
    add(0, 24'h0,    24'h0,     0, 1, 0, 0,    0, 0, 24'h3,    24'h33,    0, 0);
    add(1, 24'h55,   24'h123456,0, 1, 0, 0,    1, 1, 24'h3,    24'h33,    0, 0);
    add(1, 24'h66,   24'h654321,0, 1, 0, 0,    2, 1, 24'h3,    24'h33,    0, 0);
    add(0, 24'h0,    24'h0,     0, 1, 1, 0,    1, 1, 24'h55,   24'h0,     0, 0);
    add(0, 24'h0,    24'h0,     0, 1, 1, 0,    1, 1, 24'h55,   24'h0,     0, 0);
    add(0, 24'h0,    24'h0,     0, 1, 1, 0,    1, 1, 24'h55,   24'h0,     0, 0);
    add(0, 24'h0,    24'h0,     0, 1, 1, 0,    1, 1, 24'h55,   24'h0,     0, 0);
    add(0, 24'h0,    24'h0,     0, 1, 1, 0,    1, 1, 24'h55,   24'h0,     0, 0);
    add(0, 24'h0,    24'h0,     0, 1, 0, 0,    1, 1, 24'h55,   24'h0,     0, 0);
    add(0, 24'h0,    24'h0,     0, 1, 1, 0,    0, 0, 24'h66,   24'h0,     0, 0);
    add(1, 24'h77,   24'h777,   0, 1, 0, 0,    1, 1, 24'h66,   24'h0,     0, 0);
    add(0, 24'h0,    24'h0,     0, 0, 1, 0,    1, 1, 24'h66,   24'h0,     0, 0);
    add(0, 24'h0,    24'h0,     0, 1, 0, 0,    1, 1, 24'h66,   24'h0,     0, 0);
    add(0, 24'h0,    24'h0,     0, 1, 1, 0,    0, 0, 24'h77,   24'h0,     0, 0);
    add(0, 24'h0,    24'h0,     0, 1, 0, 0,    0, 0, 24'h77,   24'h0,     0, 0);
    add(1, 24'h88,   24'h888,   0, 1, 1, 0,    1, 1, 24'h77,   24'h0,     0, 1);
    add(0, 24'h0,    24'h0,     0, 1, 0, 0,    1, 1, 24'h77,   24'h0,     0, 1);
    add(0, 24'h0,    24'h0,     0, 1, 1, 0,    0, 0, 24'h88,   24'h0,     0, 1);
    add(0, 24'h0,    24'h0,     0, 1, 0, 1,    0, 0, 24'h88,   24'h0,     0, 0);
    add(0, 24'h0,    24'h0,     0, 1, 1, 1,    0, 0, 24'h88,   24'h0,     0, 1);
    add(0, 24'h0,    24'h0,     0, 1, 0, 1,    0, 0, 24'h88,   24'h0,     0, 0);

    foreach (vq[i]) begin
      IQ_VALID = vq[i].v; set_sample(vq[i].r1i, vq[i].r2i);
      rx2_enable = vq[i].en; IQ_RX_READ_REQ = vq[i].req;
      IQ_RX_READ_CLK = vq[i].rclk; CLEAR_FLAGS = vq[i].clr;
      tick();
      chk($sformatf("vec%0d_level", i), FIFO_LEVEL, vq[i].lvl);
      chk($sformatf("vec%0d_ready", i), DATA_READY, vq[i].rdy);
      chk($sformatf("vec%0d_rd1i", i), RD_RX1_I, vq[i].e1i);
      chk($sformatf("vec%0d_rd2i", i), RD_RX2_I, vq[i].e2i);
      chk($sformatf("vec%0d_ovr", i), IQ_OVERRUN, vq[i].ovr);
      chk($sformatf("vec%0d_und", i), IQ_UNDERRUN, vq[i].und);
    end
    IQ_VALID = 1'b0; IQ_RX_READ_CLK = 1'b0; CLEAR_FLAGS = 1'b0; IQ_RX_READ_REQ = 1'b1;

    // Overrun: 17 pushes into 16 slots, drain, 17th frame must be absent.
    rx2_enable = 1'b1; tick();
    push_n(16, 100);
    chk("ovr_not_before_full", IQ_OVERRUN, 0);
    push_n(1, 116);
    chk("ovr_level16", FIFO_LEVEL, 16);
    chk("ovr_set", IQ_OVERRUN, 1);
    for (int k = 0; k < 16; k++) begin
      pop_once();
      chk($sformatf("ovr_drain%0d_rd1i", k), RD_RX1_I, SW'(100 + k));
      e = ~(SW'(100 + k));
      chk($sformatf("ovr_drain%0d_rd1q", k), RD_RX1_Q, e);
      chk($sformatf("ovr_drain%0d_rd2i", k), RD_RX2_I, SW'(200 + k));
      e = ~(SW'(200 + k));
      chk($sformatf("ovr_drain%0d_rd2q", k), RD_RX2_Q, e);
      IQ_RX_READ_CLK = 1'b0; tick();
    end
    chk("ovr_drained_level", FIFO_LEVEL, 0);
    chk("ovr_sticky", IQ_OVERRUN, 1);
    pop_once();
    chk("ovr_17th_absent_und", IQ_UNDERRUN, 1);
    chk("ovr_17th_absent_rd", RD_RX1_I, SW'(115));
    IQ_RX_READ_CLK = 1'b0; CLEAR_FLAGS = 1'b1; tick(); CLEAR_FLAGS = 1'b0;
    chk("clear_ovr", IQ_OVERRUN, 0);
    chk("clear_und", IQ_UNDERRUN, 0);

    // Full FIFO with coincident push and pop.
    push_n(16, 300);
    chk("full_level", FIFO_LEVEL, 16);
    IQ_VALID = 1'b1; set_sample(SW'(316), SW'(416)); IQ_RX_READ_CLK = 1'b1; tick();
    IQ_VALID = 1'b0; IQ_RX_READ_CLK = 1'b0;
    chk("fullpp_level", FIFO_LEVEL, 16);
    chk("fullpp_ovr", IQ_OVERRUN, 0);
    chk("fullpp_rd1i", RD_RX1_I, SW'(300));
    tick();
    for (int k = 1; k <= 16; k++) begin
      pop_once();
      chk($sformatf("fullpp_drain%0d", k), RD_RX1_I, SW'(300 + k));
      IQ_RX_READ_CLK = 1'b0; tick();
    end
    chk("fullpp_empty", FIFO_LEVEL, 0);
    chk("fullpp_no_ovr", IQ_OVERRUN, 0);

    // rx2_enable toggle flushes, coincident push discarded.
    push_n(5, 500);
    chk("flush_pre_level", FIFO_LEVEL, 5);
    rx2_enable = 1'b0; IQ_VALID = 1'b1; set_sample(SW'(999), SW'(999)); tick();
    IQ_VALID = 1'b0;
    chk("flush_level", FIFO_LEVEL, 0);
    chk("flush_ready", DATA_READY, 0);
    chk("flush_ovr", IQ_OVERRUN, 0);
    chk("flush_rd_hold", RD_RX1_I, SW'(316));
    tick();
    chk("flush_push_gone", FIFO_LEVEL, 0);

    // Reset mid-stream at level 7 with a sticky flag set.
    pop_once(); IQ_RX_READ_CLK = 1'b0; tick();
    chk("rst_pre_und", IQ_UNDERRUN, 1);
    push_n(7, 700);
    chk("rst_pre_level", FIFO_LEVEL, 7);
    reset = 1'b1; tick();
    chk("rst_level", FIFO_LEVEL, 0);
    chk("rst_ready", DATA_READY, 0);
    chk("rst_und", IQ_UNDERRUN, 0);
    chk("rst_ovr", IQ_OVERRUN, 0);
    chk("rst_rd1i", RD_RX1_I, 0);
    chk("rst_rd1q", RD_RX1_Q, 0);
    chk("rst_rd2i", RD_RX2_I, 0);
    chk("rst_rd2q", RD_RX2_Q, 0);

    // READ_CLK held high across reset release must not pop.
    IQ_RX_READ_CLK = 1'b1; tick();
    reset = 1'b0; IQ_VALID = 1'b1; set_sample(24'h99, 24'h0); tick();
    IQ_VALID = 1'b0;
    chk("rel_level", FIFO_LEVEL, 1);
    chk("rel_und", IQ_UNDERRUN, 0);
    tick();
    chk("rel_hold_level", FIFO_LEVEL, 1);
    chk("rel_hold_und", IQ_UNDERRUN, 0);
    IQ_RX_READ_CLK = 1'b0; tick();
    pop_once();
    chk("rel_pop_level", FIFO_LEVEL, 0);
    chk("rel_pop_rd1i", RD_RX1_I, 24'h99);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
